// File: rtl/reg_file_mp_pkg.sv
// Shared defaults for the multi-port register file.
// The default build is read-first. Define REG_FILE_BYPASS_EN for write-first reads.
package reg_file_mp_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM_RD     = 2;
  localparam int REG_NUM_WR     = 1;

  // Number of registers addressed by an address of the given width.
  function automatic int rf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_wr_sel.sv
// Write select for one register.
// Finds which enabled write ports target REG_IDX. When several ports hit it,
// the highest-index port supplies the data.
// This block's outputs drive both the storage update and the bypass path.
module reg_file_wr_sel
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_WR     = REG_NUM_WR,
  parameter int REG_IDX    = 0,
  parameter bit ZERO_REG0  = 1'b1
) (
  input  logic [NUM_WR-1:0]                 write,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] addr_w,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] data_w,
  output logic                              we,
  output logic [DATA_WIDTH-1:0]             wdata
);

  localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(REG_IDX);
  localparam bit IS_ZERO = ZERO_REG0 && (REG_IDX == 0);

  // Ports are scanned in ascending order, so a later match overrides an earlier one.
  // For the hardwired zero register, the enable is forced off. A losing port never falls through to it.
  always_comb begin
    we    = 1'b0;
    wdata = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (write[k] && (addr_w[k] == MY_ADDR)) begin
        we    = 1'b1;
        wdata = data_w[k];
      end
    end
    if (IS_ZERO) we = 1'b0;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with registered read ports.
// It has NUM_WR write ports with highest-index priority on collisions.
// It has NUM_RD read ports sharing a single READ enable.
// Register 0 can optionally be hardwired to zero.
// Define REG_FILE_BYPASS_EN to make same-cycle read-after-write return the new data.
// Without it, such a read returns the old contents.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_RD     = REG_NUM_RD,
  parameter int NUM_WR     = REG_NUM_WR,
  parameter bit ZERO_REG0  = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         READ,
  input  logic [NUM_WR-1:0]            WRITE,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] ADDR_W,
  input  logic [NUM_WR*DATA_WIDTH-1:0] DATA_W,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ADDR_R,
  output logic [NUM_RD*DATA_WIDTH-1:0] DATA_R
);

  localparam int DEPTH = rf_depth(ADDR_WIDTH);

  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] addr_w_a;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] data_w_a;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] addr_r_a;

  logic [DEPTH-1:0]                  we;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  wdata;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem;
  logic [DATA_WIDTH-1:0]             rd_val [NUM_RD];
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] data_r_q;

  assign addr_w_a = ADDR_W;
  assign data_w_a = DATA_W;
  assign addr_r_a = ADDR_R;
  assign DATA_R   = data_r_q;

  // One write selector per register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    reg_file_wr_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WR     (NUM_WR),
      .REG_IDX    (i),
      .ZERO_REG0  (ZERO_REG0)
    ) u_wr_sel (
      .write  (WRITE),
      .addr_w (addr_w_a),
      .data_w (data_w_a),
      .we     (we[i]),
      .wdata  (wdata[i])
    );
  end

  // Per-port read mux. The zero register overrides the bypass path as well.
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit_zero;
    assign ra       = addr_r_a[j];
    assign hit_zero = ZERO_REG0 && (ra == '0);
`ifdef REG_FILE_BYPASS_EN
    assign rd_val[j] = hit_zero ? '0 : (we[ra] ? wdata[ra] : mem[ra]);
`else
    assign rd_val[j] = hit_zero ? '0 : mem[ra];
`endif
  end

  // Storage update. A synchronous reset clears every register and blocks writes that cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we[i]) mem[i] <= wdata[i];
    end
  end

  // Registered read outputs. They hold their value while READ is low.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_r_q <= '0;
    end else if (READ) begin
      for (int j = 0; j < NUM_RD; j++)
        data_r_q[j] <= rd_val[j];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp (2 read ports, 2 write ports, zero register on).
// Build with or without REG_FILE_BYPASS_EN. The reference model follows the same macro.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam bit ZR = 1'b1;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_en;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] addr_w;
  logic [NW*DW-1:0] data_w;
  logic [NR*AW-1:0] addr_r;
  logic [NR*DW-1:0] data_r;

  reg_file_mp #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_RD (NR), .NUM_WR (NW), .ZERO_REG0 (ZR)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .READ   (rd_en),
    .WRITE  (wr_en),
    .ADDR_W (addr_w),
    .DATA_W (data_w),
    .ADDR_R (addr_r),
    .DATA_R (data_r)
  );

  always #5 clk = ~clk;

  // Reference state: register contents and the visible read outputs.
  logic [DW-1:0]             mem_m [32];
  logic [NR-1:0][DW-1:0]     rd_m;
  logic [NR-1:0][DW-1:0]     sb_q [$];
  int                        tests = 0;
  int                        fails = 0;

  // Monitor: one expectation per clock edge, checked on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      logic [NR-1:0][DW-1:0] exp_v;
      exp_v = sb_q.pop_front();
      for (int j = 0; j < NR; j++) begin
        tests++;
        if (data_r[j*DW +: DW] !== exp_v[j]) begin
          fails++;
          $display("FAIL data_r port%0d at %0t: got %h expected %h", j, $time, data_r[j*DW +: DW], exp_v[j]);
        end
      end
    end
  end

  // Drive one edge and advance the model.
  // Writes collect into an address->data map in port order, so a later port overwrites an earlier one.
  task automatic cycle(input bit r, input bit rd, input bit [1:0] we,
                       input int a0, input logic [DW-1:0] d0,
                       input int a1, input logic [DW-1:0] d1,
                       input int ra0, input int ra1);
    logic [DW-1:0] pend [int];
    int ra;
    rst    = r;
    rd_en  = rd;
    wr_en  = we;
    addr_w = {AW'(a1), AW'(a0)};
    data_w = {d1, d0};
    addr_r = {AW'(ra1), AW'(ra0)};
    if (!r) begin
      for (int m = 0; m < 32; m++) mem_m[m] = '0;
      rd_m = '0;
    end else begin
      if (we[0] && !(ZR && a0 == 0)) pend[a0] = d0;
      if (we[1] && !(ZR && a1 == 0)) pend[a1] = d1;
      if (rd) begin
        for (int j = 0; j < NR; j++) begin
          ra = (j == 0) ? ra0 : ra1;
          if (ZR && ra == 0)                  rd_m[j] = '0;
          else if (BYP && pend.exists(ra))    rd_m[j] = pend[ra];
          else                                rd_m[j] = mem_m[ra];
        end
      end
      foreach (pend[a]) mem_m[a] = pend[a];
    end
    @(posedge clk);
    sb_q.push_back(rd_m);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    cycle(1, 0, 2'b01, a, d, 0, '0, 0, 0);
  endtask

  task automatic rdp(input int r0, input int r1);
    cycle(1, 1, 2'b00, 0, '0, 0, '0, r0, r1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = '0; addr_w = '0; data_w = '0; addr_r = '0;
    for (int m = 0; m < 32; m++) mem_m[m] = '0;
    rd_m = '0;
    #1;
    // Reset state.
    cycle(0, 0, 2'b00, 0, '0, 0, '0, 0, 0);
    cycle(0, 1, 2'b11, 3, 32'h1234, 4, 32'h5678, 3, 4);
    // Reset clears written data.
    wr(5, 32'hFFFF_FFFF);
    rdp(5, 5);
    cycle(0, 0, 2'b00, 0, '0, 0, '0, 0, 0);
    rdp(5, 5);
    // Fill and readback, two patterns.
    for (int pat = 0; pat < 2; pat++) begin
      for (int i = 0; i < 32; i++) wr(i, (pat == 0) ? DW'(i) : 32'hA5A5_0000 + DW'(i));
      for (int i = 0; i < 32; i++) rdp(i, 31 - i);
    end
    // Write conflict on the same address: the higher-index port wins.
    cycle(1, 0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0);
    rdp(7, 7);
    // Conflict on register 0 stays discarded.
    cycle(1, 0, 2'b11, 0, 32'h33, 0, 32'h44, 0, 0);
    rdp(0, 7);
    // Write to the zero register.
    wr(0, 32'hDEAD_BEEF);
    rdp(0, 0);
    // Same-cycle read after write.
    wr(3, 32'h1);
    cycle(1, 1, 2'b01, 3, 32'h2, 0, '0, 3, 3);
    rdp(3, 3);
    // Same-cycle write on port 1 with a read of register 0.
    cycle(1, 1, 2'b10, 0, '0, 0, 32'h77, 0, 3);
    // Hold while READ is low and the addresses move.
    for (int i = 0; i < 4; i++) cycle(1, 0, 2'b00, 0, '0, 0, '0, i + 8, 20 - i);
    // Reset concurrent with a write.
    cycle(0, 0, 2'b01, 9, 32'h55, 0, '0, 0, 0);
    rdp(9, 9);
    // Randomized traffic. Narrow addresses force conflicts and zero-register hits.
    for (int n = 0; n < 300; n++) begin
      bit narrow;
      narrow = ($urandom_range(1) == 0);
      cycle(($urandom_range(49) != 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
            narrow ? $urandom_range(3) : $urandom_range(31), $urandom,
            narrow ? $urandom_range(3) : $urandom_range(31), $urandom,
            narrow ? $urandom_range(3) : $urandom_range(31),
            narrow ? $urandom_range(3) : $urandom_range(31));
    end
    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
